// File: rtl/iq_stream_packer.sv
// iq_stream_packer: packs decimated I/Q sample pairs into 32-bit words, buffers
// them in a FIFO and delivers them on a valid/ready stream with a frame-end
// marker and a saturating count of samples dropped while the FIFO was full.
module iq_stream_packer #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned FRAME_LEN = 1024,
  localparam int unsigned LW       = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               in_valid,
  input  logic signed [15:0] in_i,
  input  logic signed [15:0] in_q,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [31:0]        m_data,
  output logic               m_last,
  output logic [LW-1:0]      level,
  output logic [15:0]        overflow_cnt,
  input  logic               overflow_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = $clog2(FRAME_LEN);

  // Each entry is {last, q, i}.
  logic [32:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [FW-1:0] r_frame_cnt;
  logic [15:0]   r_ovf_cnt;

  logic          w_full;
  logic          w_wr;
  logic          w_drop;
  logic          w_valid;
  logic          w_rd;
  logic          w_last;
  logic [32:0]   w_head;

  // Full is judged on the registered level only, so a same-cycle read never
  // makes room for a write.
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_wr    = in_valid & enable & ~w_full & ~reset;
  assign w_drop  = in_valid & enable & w_full;
  // Valid is suppressed while reset is held so nothing leaks out mid-reset.
  assign w_valid = (r_level != '0) & ~reset;
  assign w_rd    = w_valid & m_ready;
  assign w_last  = (r_frame_cnt == FW'(FRAME_LEN - 1));
  assign w_head  = r_mem[r_rd_ptr];

  // Storage array; no reset needed since the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {w_last, in_q, in_i};
    end
  end

  // Read/write pointers and occupancy level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Frame position counter; advances only on accepted samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (w_wr) begin
      if (w_last) begin
        r_frame_cnt <= '0;
      end else begin
        r_frame_cnt <= r_frame_cnt + FW'(1);
      end
    end
  end

  // Saturating drop counter; a clear coinciding with a drop leaves it at one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf_cnt <= '0;
    end else if (overflow_clr) begin
      r_ovf_cnt <= w_drop ? 16'd1 : 16'd0;
    end else if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  // Head word is forced to zero whenever no word is being offered.
  always_comb begin
    m_valid      = w_valid;
    m_data       = w_valid ? w_head[31:0] : 32'd0;
    m_last       = w_valid & w_head[32];
    level        = r_level;
    overflow_cnt = r_ovf_cnt;
  end

endmodule

// File: tb/tb_iq_stream_packer.sv
// Directed bench for iq_stream_packer with a small FIFO and short frames, plus a
// randomised-backpressure scoreboard run and a mid-stream reset.
module tb_iq_stream_packer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        in_valid;
  logic [15:0] in_i;
  logic [15:0] in_q;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic [2:0]  level;
  logic [15:0] overflow_cnt;
  logic        overflow_clr;

  int n_cmp;
  int n_err;

  logic [32:0] sb[$];
  logic [32:0] exp_word;
  logic [15:0] v16;
  logic [31:0] rnd;
  logic        rdy;
  int          mcnt;
  int          drain;

  iq_stream_packer #(
    .DEPTH    (4),
    .FRAME_LEN(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .in_valid    (in_valid),
    .in_i        (in_i),
    .in_q        (in_q),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .level       (level),
    .overflow_cnt(overflow_cnt),
    .overflow_clr(overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [15:0] q, input logic [15:0] i);
    return {q, i};
  endfunction

  task automatic do_reset(input string tag);
    reset = 1'b1;
    tick();
    check({tag, "_valid"}, m_valid, 0);
    check({tag, "_data"}, m_data, 0);
    check({tag, "_last"}, m_last, 0);
    check({tag, "_level"}, level, 0);
    check({tag, "_ovf"}, overflow_cnt, 0);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] t1_exp [3];
    t1_exp[0] = 32'hFFFF0001;
    t1_exp[1] = 32'hFFFE0002;
    t1_exp[2] = 32'hFFFD0003;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; in_i = '0; in_q = '0;
    m_ready = 1'b0; overflow_clr = 1'b0;
    tick();
    do_reset("rst0");

    // 1: pass-through latency of one cycle
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      v16 = 16'(k + 1);
      in_valid = 1'b1; in_i = v16; in_q = -v16;
      tick();
      in_valid = 1'b0;
      check("t1_valid", m_valid, 1);
      check("t1_data", m_data, t1_exp[k]);
      check("t1_last", m_last, 0);
      check("t1_level", level, 1);
      tick();
      check("t1_empty_valid", m_valid, 0);
      check("t1_empty_level", level, 0);
    end

    // 2: frame markers on every fourth word, 12 back-to-back samples
    do_reset("rst2");
    m_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      in_valid = 1'b1; in_i = 16'h0100 + 16'(k); in_q = 16'hA000 + 16'(k);
      tick();
      check("t2_data", m_data, mk(16'hA000 + 16'(k), 16'h0100 + 16'(k)));
      check("t2_last", m_last, (k % 4) == 3);
      check("t2_level", level, 1);
    end
    in_valid = 1'b0;
    tick();
    check("t2_drained", level, 0);

    // 3: fill with no readiness, two drops, then ordered drain
    do_reset("rst3");
    m_ready = 1'b0;
    for (int j = 0; j < 6; j++) begin
      in_valid = 1'b1; in_i = 16'h0010 + 16'(j); in_q = 16'hC000 + 16'(j);
      tick();
      check("t3_level", level, (j < 4) ? j + 1 : 4);
      check("t3_ovf", overflow_cnt, (j < 4) ? 0 : j - 3);
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("t3_hold_valid", m_valid, 1);
    check("t3_hold_data", m_data, mk(16'hC000, 16'h0010));
    for (int j = 0; j < 4; j++) begin
      check("t3_drain_data", m_data, mk(16'hC000 + 16'(j), 16'h0010 + 16'(j)));
      check("t3_drain_last", m_last, j == 3);
      check("t3_drain_level", level, 4 - j);
      m_ready = 1'b1;
      tick();
    end
    check("t3_end_valid", m_valid, 0);
    check("t3_end_level", level, 0);
    check("t3_end_ovf", overflow_cnt, 2);

    // 4: drop while full even with a same-cycle read; clear racing a drop
    do_reset("rst4");
    m_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1; in_i = 16'h6000 + 16'(j); in_q = 16'h5000 + 16'(j);
      tick();
    end
    check("t4_full", level, 4);
    m_ready = 1'b1; in_i = 16'hDEAD; in_q = 16'hBEEF;
    tick();
    check("t4_rd_drop_level", level, 3);
    check("t4_rd_drop_ovf", overflow_cnt, 1);
    check("t4_rd_drop_head", m_data, mk(16'h5001, 16'h6001));
    m_ready = 1'b0; in_i = 16'h6004; in_q = 16'h5004;
    tick();
    check("t4_refill_level", level, 4);
    check("t4_refill_ovf", overflow_cnt, 1);
    in_i = 16'hDEAD; in_q = 16'hBEEF;
    tick();
    check("t4_drop2_ovf", overflow_cnt, 2);
    overflow_clr = 1'b1;
    tick();
    check("t4_clr_drop_ovf", overflow_cnt, 1);
    check("t4_clr_drop_level", level, 4);
    in_valid = 1'b0;
    tick();
    check("t4_clr_ovf", overflow_cnt, 0);
    overflow_clr = 1'b0;
    for (int j = 1; j < 5; j++) begin
      check("t4_drain_data", m_data, mk(16'h5000 + 16'(j), 16'h6000 + 16'(j)));
      check("t4_drain_last", m_last, j == 3);
      m_ready = 1'b1;
      tick();
    end
    m_ready = 1'b0;
    check("t4_end_valid", m_valid, 0);

    // 5: enable low ignores strobes; frame counter sits at 1 from test 4
    enable = 1'b0; m_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      in_valid = 1'b1; in_i = 16'h1234; in_q = 16'h5678;
      tick();
      check("t5_dis_level", level, 0);
      check("t5_dis_valid", m_valid, 0);
      check("t5_dis_ovf", overflow_cnt, 0);
    end
    enable = 1'b1; m_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1; in_i = 16'h7100 + 16'(j); in_q = 16'h7000 + 16'(j);
      tick();
    end
    enable = 1'b0; in_i = 16'h1111; in_q = 16'h2222;
    tick();
    tick();
    in_valid = 1'b0;
    check("t5_keep_level", level, 3);
    for (int j = 0; j < 3; j++) begin
      check("t5_drain_data", m_data, mk(16'h7000 + 16'(j), 16'h7100 + 16'(j)));
      check("t5_drain_last", m_last, j == 2);
      m_ready = 1'b1;
      tick();
    end
    check("t5_end_level", level, 0);
    enable = 1'b1;

    // 6: random backpressure, one sample every 32 cycles, scoreboarded
    do_reset("rst6");
    mcnt = 0;
    for (int c = 0; c < 600 * 32; c++) begin
      rdy = 1'($urandom_range(0, 1));
      if (m_valid && rdy) begin
        if (sb.size() == 0) begin
          check("t6_spurious", 1, 0);
        end else begin
          exp_word = sb.pop_front();
          check("t6_word", {m_last, m_data}, exp_word);
        end
      end
      m_ready = rdy;
      if ((c % 32) == 0) begin
        rnd = $urandom;
        in_valid = 1'b1; in_i = rnd[15:0]; in_q = rnd[31:16];
        sb.push_back({mcnt == 3, rnd});
        mcnt = (mcnt + 1) % 4;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    drain = 0;
    while (sb.size() != 0 && drain < 50) begin
      if (m_valid) begin
        exp_word = sb.pop_front();
        check("t6_word", {m_last, m_data}, exp_word);
      end
      m_ready = 1'b1;
      tick();
      drain++;
    end
    check("t6_left", sb.size(), 0);
    check("t6_ovf", overflow_cnt, 0);
    m_ready = 1'b0;
    tick();
    check("t6_level", level, 0);

    // Mid-stream reset discards buffered words
    for (int j = 0; j < 2; j++) begin
      in_valid = 1'b1; in_i = 16'h0A0A; in_q = 16'h0B0B;
      tick();
    end
    in_valid = 1'b0;
    check("t6_pre_rst_level", level, 2);
    reset = 1'b1;
    #1;
    check("t6_in_rst_valid", m_valid, 0);
    tick();
    check("t6_rst_valid", m_valid, 0);
    check("t6_rst_level", level, 0);
    reset = 1'b0;
    m_ready = 1'b1;
    tick();
    check("t6_post_rst_valid", m_valid, 0);
    check("t6_post_rst_level", level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
